// File: rtl/ext_mem_reqrsp_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ext_mem_reqrsp_ctrl_pkg
// Shared types and constants for the external memory reqrsp slave.
//   EXT_MEM_BASE / EXT_MEM_SIZE : default address window of the TCM.
//   ext_mem_req_t               : flat request fields bundled after unpacking.
//   ext_mem_rsp_t               : one response entry {data, err}.
//   size_aligned()              : alignment check for a byte offset and size.
// ---------------------------------------------------------------------------
package ext_mem_reqrsp_ctrl_pkg;

  localparam logic [31:0] EXT_MEM_BASE = 32'h0000_1000;
  localparam logic [31:0] EXT_MEM_SIZE = 32'h0002_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  size;
  } ext_mem_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } ext_mem_rsp_t;

  // Size 3 (8 bytes) cannot be served by a 32-bit port and is treated as
  // misaligned.
  function automatic logic size_aligned(input logic [1:0] off_lsb,
                                        input logic [1:0] size);
    logic r;
    case (size)
      2'd0:    r = 1'b1;
      2'd1:    r = ~off_lsb[0];
      2'd2:    r = (off_lsb == 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ext_mem_rsp_fifo.sv
// ---------------------------------------------------------------------------
// ext_mem_rsp_fifo
// Response buffer holding DEPTH entries of ext_mem_rsp_t.
//   clk_i, rst_ni : clock, asynchronous active-low reset (clears pointers).
//   push_i/data_i : write an entry (ignored when full).
//   pop_i         : drop the head entry (ignored when empty).
//   head_o        : current head entry.
//   full_o/empty_o: occupancy flags; count_o: number of stored entries.
// Simultaneous push and pop keep the count unchanged.
// ---------------------------------------------------------------------------
module ext_mem_rsp_fifo
  import ext_mem_reqrsp_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  ext_mem_rsp_t  data_i,
  input  logic          pop_i,
  output ext_mem_rsp_t  head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ext_mem_rsp_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (r_count == CW'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign head_o  = r_mem[r_rd_ptr];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through the count.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/ext_mem_reqrsp_ctrl.sv
// ---------------------------------------------------------------------------
// ext_mem_reqrsp_ctrl
// 32-bit reqrsp slave in front of a single-port TCM-style SRAM. Decodes the
// address window, checks size/alignment, answers bad accesses with an error
// response and buffers responses so p_ready_i backpressure never drops data.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   q_valid_i/q_ready_o        request handshake
//   q_addr_i, q_write_i, q_data_i, q_strb_i, q_size_i   request fields
//   p_valid_o/p_ready_i        response handshake
//   p_data_o, p_error_o        response fields
//   mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  SRAM drive
//   mem_rdata_i                SRAM read data, one cycle after mem_en_o
//   err_cnt_o, err_addr_o, err_clr_i   only with EXT_MEM_ERR_STATS_EN
//
// Handshake: both channels use valid/ready. A transfer happens on a rising
// edge where valid and ready are both 1. The producer holds valid and all
// fields stable until that edge; ready may change freely, and valid never
// depends combinationally on ready.
//
// Optional feature macro: EXT_MEM_ERR_STATS_EN (error counter/address).
// ---------------------------------------------------------------------------
module ext_mem_reqrsp_ctrl
  import ext_mem_reqrsp_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = EXT_MEM_BASE,
  parameter logic [31:0] MEM_BYTES = EXT_MEM_SIZE,
  parameter int unsigned RSP_DEPTH = 2,
  parameter int unsigned AW        = $clog2(MEM_BYTES)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          q_valid_i,
  output logic          q_ready_o,
  input  logic [31:0]   q_addr_i,
  input  logic          q_write_i,
  input  logic [31:0]   q_data_i,
  input  logic [3:0]    q_strb_i,
  input  logic [1:0]    q_size_i,
  output logic          p_valid_o,
  input  logic          p_ready_i,
  output logic [31:0]   p_data_o,
  output logic          p_error_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [3:0]    mem_be_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i
`ifdef EXT_MEM_ERR_STATS_EN
  ,
  input  logic          err_clr_i,
  output logic [15:0]   err_cnt_o,
  output logic [31:0]   err_addr_o
`endif
);

  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

  ext_mem_req_t  w_req;
  logic [31:0]   w_off;
  logic          w_in_range;
  logic          w_ok;
  logic          w_accept;
  logic          w_mem_en;

  logic          r_s1_valid;
  logic          r_s1_read;
  logic          r_s1_err;
  ext_mem_rsp_t  w_s1_rsp;

  ext_mem_rsp_t  w_head;
  ext_mem_rsp_t  w_rsp;
  logic          w_fifo_empty;
  logic          w_fifo_full;
  logic [CW-1:0] w_fifo_count;
  logic [CW-1:0] w_occ;
  logic          w_push;
  logic          w_pop;

  assign w_req = '{addr: q_addr_i, write: q_write_i, data: q_data_i,
                   strb: q_strb_i, size: q_size_i};

  // ---- window decode ----
  assign w_off      = w_req.addr - BASE_ADDR;
  assign w_in_range = (w_req.addr >= BASE_ADDR) & (w_off < MEM_BYTES);
  assign w_ok       = w_in_range & size_aligned(w_off[1:0], w_req.size);

  // Credits cover the s1 slot as well as the FIFO, so a response can always
  // be parked even if p_ready_i stays low.
  assign w_occ     = w_fifo_count + CW'(r_s1_valid);
  assign q_ready_o = rst_ni & (w_occ < CW'(RSP_DEPTH));
  assign w_accept  = q_valid_i & q_ready_o;

  // ---- SRAM drive, same cycle as acceptance ----
  // All mem_* outputs are zero unless an access is issued, keeping the bus
  // quiet during reset and on rejected requests.
  assign w_mem_en    = w_accept & w_ok;
  assign mem_en_o    = w_mem_en;
  assign mem_we_o    = w_mem_en & w_req.write;
  assign mem_be_o    = !w_mem_en ? 4'h0 : (w_req.write ? w_req.strb : 4'hF);
  assign mem_addr_o  = w_mem_en ? w_off[AW-1:0] : '0;
  assign mem_wdata_o = w_mem_en ? w_req.data : 32'h0;

  // ---- stage s1: the cycle in which mem_rdata_i is valid ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid <= 1'b0;
      r_s1_read  <= 1'b0;
      r_s1_err   <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_read <= ~w_req.write;
        r_s1_err  <= ~w_ok;
      end
    end
  end

  assign w_s1_rsp.data = (r_s1_read & ~r_s1_err) ? mem_rdata_i : 32'h0;
  assign w_s1_rsp.err  = r_s1_err;

  // ---- response selection ----
  // The FIFO head is older than s1, so it always goes first. s1 falls
  // through only when the FIFO is empty; otherwise (or if not taken) it is
  // captured into the FIFO because mem_rdata_i is valid for this cycle only.
  assign p_valid_o = ~w_fifo_empty | r_s1_valid;
  assign w_rsp     = !w_fifo_empty ? w_head : (r_s1_valid ? w_s1_rsp : '0);
  assign p_data_o  = w_rsp.data;
  assign p_error_o = w_rsp.err;

  assign w_pop  = ~w_fifo_empty & p_ready_i;
  assign w_push = r_s1_valid & ~(w_fifo_empty & p_ready_i);

  ext_mem_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .CW    (CW)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .data_i  (w_s1_rsp),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .count_o (w_fifo_count)
  );

  // Full is implied by the credit check; kept for binding checkers.
  logic w_unused_full;
  assign w_unused_full = w_fifo_full;

`ifdef EXT_MEM_ERR_STATS_EN
  logic [15:0] r_err_cnt;
  logic [31:0] r_err_addr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_cnt  <= 16'h0;
      r_err_addr <= 32'h0;
    end else if (err_clr_i) begin
      r_err_cnt  <= 16'h0;
      r_err_addr <= 32'h0;
    end else if (w_accept & ~w_ok) begin
      if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'h1;
      r_err_addr <= w_req.addr;
    end
  end

  assign err_cnt_o  = r_err_cnt;
  assign err_addr_o = r_err_addr;
`endif

endmodule

// File: tb/tb_ext_mem_reqrsp_ctrl.sv
module tb_ext_mem_reqrsp_ctrl;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] SIZE  = 32'h0002_0000;
  localparam int          DEPTH = 2;

  // ---- clock / reset ----
  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic        q_valid_i, q_ready_o, q_write_i;
  logic [31:0] q_addr_i, q_data_i;
  logic [3:0]  q_strb_i;
  logic [1:0]  q_size_i;
  logic        p_valid_o, p_ready_i, p_error_o;
  logic [31:0] p_data_o;
  logic        mem_en_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [16:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
`ifdef EXT_MEM_ERR_STATS_EN
  logic        err_clr_i;
  logic [15:0] err_cnt_o;
  logic [31:0] err_addr_o;
`endif

  ext_mem_reqrsp_ctrl dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .q_valid_i   (q_valid_i),
    .q_ready_o   (q_ready_o),
    .q_addr_i    (q_addr_i),
    .q_write_i   (q_write_i),
    .q_data_i    (q_data_i),
    .q_strb_i    (q_strb_i),
    .q_size_i    (q_size_i),
    .p_valid_o   (p_valid_o),
    .p_ready_i   (p_ready_i),
    .p_data_o    (p_data_o),
    .p_error_o   (p_error_o),
    .mem_en_o    (mem_en_o),
    .mem_we_o    (mem_we_o),
    .mem_be_o    (mem_be_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
`ifdef EXT_MEM_ERR_STATS_EN
    ,
    .err_clr_i   (err_clr_i),
    .err_cnt_o   (err_cnt_o),
    .err_addr_o  (err_addr_o)
`endif
  );

  // ---- SRAM behind the DUT (environment, not a reference) ----
  logic [31:0] sram [0:32767];
  initial begin
    for (int i = 0; i < 32768; i++) sram[i] = 32'h0;
    mem_rdata_i = 32'h0;
  end
  always @(posedge clk_i) begin
    if (mem_en_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) sram[mem_addr_o[16:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        mem_rdata_i <= sram[mem_addr_o[16:2]];
      end
    end
  end

  // ---- scoreboard and reference model ----
  logic [32:0] exp_q [$];            // {err, data} in acceptance order
  logic [31:0] ref_mem [int unsigned];
  int errors = 0;
  int checks = 0;

  function automatic logic model_ok(input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] off;
    int unsigned nbytes;
    off = a - BASE;
    if (sz == 2'd3) return 1'b0;
    nbytes = 1 << sz;
    return (a >= BASE) && (off < SIZE) && ((off % nbytes) == 0);
  endfunction

  function automatic logic [31:0] ref_rd(input int unsigned w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        q_ready, p_valid, p_error, mem_en, mem_we, acc;
    logic [31:0] p_data;
    logic [16:0] mem_addr;
    logic [3:0]  mem_be;
  } obs_t;

  // ---- driver: one clock cycle, entered and left at posedge+1 ----
  task automatic step(input logic v, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic [1:0] sz, input logic pr, output obs_t o);
    logic ok, popped;
    logic [31:0] off, tmp;
    q_valid_i = v; q_write_i = w; q_addr_i = a; q_data_i = d;
    q_strb_i = s; q_size_i = sz; p_ready_i = pr;
    #4;
    o.q_ready = q_ready_o;  o.p_valid = p_valid_o; o.p_error = p_error_o;
    o.p_data  = p_data_o;   o.mem_en  = mem_en_o;  o.mem_we  = mem_we_o;
    o.mem_addr = mem_addr_o; o.mem_be = mem_be_o;
    o.acc = v & q_ready_o;
    ok  = model_ok(a, sz);
    off = a - BASE;
    chk("q_ready", o.q_ready, (exp_q.size() < DEPTH));
    chk("p_valid", o.p_valid, (exp_q.size() > 0));
    if (o.p_valid && exp_q.size() > 0) begin
      chk("p_data", o.p_data, exp_q[0][31:0]);
      chk("p_error", o.p_error, exp_q[0][32]);
    end
    chk("mem_en", o.mem_en, o.acc & ok);
    if (o.acc && ok) begin
      chk("mem_addr", o.mem_addr, off[16:0]);
      chk("mem_we", o.mem_we, w);
      chk("mem_be", o.mem_be, w ? s : 4'hF);
    end
    popped = o.p_valid & pr;
    @(posedge clk_i);
    if (popped && exp_q.size() > 0) void'(exp_q.pop_front());
    if (o.acc) begin
      if (!ok) exp_q.push_back({1'b1, 32'h0});
      else if (w) begin
        tmp = ref_rd(off >> 2);
        for (int b = 0; b < 4; b++) if (s[b]) tmp[8*b +: 8] = d[8*b +: 8];
        ref_mem[off >> 2] = tmp;
        exp_q.push_back({1'b0, 32'h0});
      end else exp_q.push_back({1'b0, ref_rd(off >> 2)});
    end
    #1;
  endtask

  task automatic idle(input logic pr, output obs_t o);
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'd0, pr, o);
  endtask

  task automatic drain();
    obs_t o;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) idle(1'b1, o);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d pending expected=0", exp_q.size());
    end
  endtask

  // ---- directed vector table ----
  typedef struct {
    logic        wr;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
    logic [1:0]  size;
    logic        exp_en;
    logic [16:0] exp_maddr;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;
  vec_t vecs [13];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    logic done;
    vecs[0]  = '{1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 2'd2, 1, 17'h0,     32'h0,         0};
    vecs[1]  = '{0, 32'h0000_1000, 32'h0,         4'h0, 2'd2, 1, 17'h0,     32'hDEAD_BEEF, 0};
    vecs[2]  = '{0, 32'h0000_0FFC, 32'h0,         4'h0, 2'd2, 0, 17'h0,     32'h0,         1};
    vecs[3]  = '{1, 32'h0002_1000, 32'h5555_AAAA, 4'hF, 2'd2, 0, 17'h0,     32'h0,         1};
    vecs[4]  = '{0, 32'h0000_1002, 32'h0,         4'h0, 2'd2, 0, 17'h0,     32'h0,         1};
    vecs[5]  = '{1, 32'h0000_1004, 32'h1234_5678, 4'h3, 2'd2, 1, 17'h4,     32'h0,         0};
    vecs[6]  = '{0, 32'h0000_1004, 32'h0,         4'h0, 2'd2, 1, 17'h4,     32'h0000_5678, 0};
    vecs[7]  = '{0, 32'h0000_1001, 32'h0,         4'h0, 2'd0, 1, 17'h1,     32'hDEAD_BEEF, 0};
    vecs[8]  = '{0, 32'h0000_1002, 32'h0,         4'h0, 2'd1, 1, 17'h2,     32'hDEAD_BEEF, 0};
    vecs[9]  = '{0, 32'h0000_1001, 32'h0,         4'h0, 2'd1, 0, 17'h0,     32'h0,         1};
    vecs[10] = '{0, 32'h0000_1000, 32'h0,         4'h0, 2'd3, 0, 17'h0,     32'h0,         1};
    vecs[11] = '{0, 32'h0002_0FFC, 32'h0,         4'h0, 2'd2, 1, 17'h1FFFC, 32'h0,         0};
    vecs[12] = '{0, 32'hFFFF_FFFC, 32'h0,         4'h0, 2'd2, 0, 17'h0,     32'h0,         1};

    // ---- reset values ----
    rst_ni = 1'b0; p_ready_i = 1'b1;
    q_valid_i = 1'b1; q_write_i = 1'b1; q_addr_i = 32'h1000;
    q_data_i = 32'hFFFF_FFFF; q_strb_i = 4'hF; q_size_i = 2'd2;
`ifdef EXT_MEM_ERR_STATS_EN
    err_clr_i = 1'b0;
`endif
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_q_ready", q_ready_o, 1'b0);
    chk("rst_p_valid", p_valid_o, 1'b0);
    chk("rst_p_data", p_data_o, 32'h0);
    chk("rst_p_error", p_error_o, 1'b0);
    chk("rst_mem_en", mem_en_o, 1'b0);
    chk("rst_mem_we", mem_we_o, 1'b0);
    chk("rst_mem_be", mem_be_o, 4'h0);
    chk("rst_mem_addr", mem_addr_o, 17'h0);
    chk("rst_mem_wdata", mem_wdata_o, 32'h0);
`ifdef EXT_MEM_ERR_STATS_EN
    chk("rst_err_cnt", err_cnt_o, 16'h0);
    chk("rst_err_addr", err_addr_o, 32'h0);
`endif
    q_valid_i = 1'b0;
    rst_ni = 1'b1;
    #1;
    chk("rel_q_ready", q_ready_o, 1'b1);
    @(posedge clk_i); #1;

    // ---- table: each request followed by one idle cycle ----
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
           vecs[i].size, 1'b1, o);
      chk($sformatf("tbl%0d_acc", i), o.acc, 1'b1);
      chk($sformatf("tbl%0d_en", i), o.mem_en, vecs[i].exp_en);
      if (vecs[i].exp_en) chk($sformatf("tbl%0d_maddr", i), o.mem_addr, vecs[i].exp_maddr);
      idle(1'b1, o);
      chk($sformatf("tbl%0d_pvalid", i), o.p_valid, 1'b1);
      chk($sformatf("tbl%0d_data", i), o.p_data, vecs[i].exp_data);
      chk($sformatf("tbl%0d_err", i), o.p_error, vecs[i].exp_err);
    end
    drain();

    // ---- back-to-back reads at full rate ----
    step(1'b1, 1'b0, 32'h1004, 32'h0, 4'h0, 2'd2, 1'b1, o);
    chk("bb0_ready", o.q_ready, 1'b1);
    step(1'b1, 1'b0, 32'h1008, 32'h0, 4'h0, 2'd2, 1'b1, o);
    chk("bb1_ready", o.q_ready, 1'b1);
    chk("bb1_pvalid", o.p_valid, 1'b1);
    chk("bb1_data", o.p_data, 32'h0000_5678);
    step(1'b1, 1'b0, 32'h100C, 32'h0, 4'h0, 2'd2, 1'b1, o);
    chk("bb2_ready", o.q_ready, 1'b1);
    chk("bb2_pvalid", o.p_valid, 1'b1);
    idle(1'b1, o);
    chk("bb3_pvalid", o.p_valid, 1'b1);
    drain();

    // ---- backpressure: only two requests fit ----
    step(1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, 2'd2, 1'b0, o);
    chk("bp0_acc", o.acc, 1'b1);
    step(1'b1, 1'b0, 32'h1004, 32'h0, 4'h0, 2'd2, 1'b0, o);
    chk("bp1_acc", o.acc, 1'b1);
    step(1'b1, 1'b0, 32'h1008, 32'h0, 4'h0, 2'd2, 1'b0, o);
    chk("bp2_ready", o.q_ready, 1'b0);
    step(1'b1, 1'b0, 32'h1008, 32'h0, 4'h0, 2'd2, 1'b0, o);
    chk("bp3_ready", o.q_ready, 1'b0);
    chk("bp3_head", o.p_data, 32'hDEAD_BEEF);
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      step(1'b1, 1'b0, 32'h1008, 32'h0, 4'h0, 2'd2, 1'b1, o);
      done = o.acc;
    end
    chk("bp_third_acc", done, 1'b1);
    drain();

    // ---- reset while two responses are pending ----
    step(1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, 2'd2, 1'b0, o);
    step(1'b1, 1'b0, 32'h1004, 32'h0, 4'h0, 2'd2, 1'b0, o);
    q_valid_i = 1'b0;
    #1;
    chk("pre_rst_pvalid", p_valid_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_pvalid", p_valid_o, 1'b0);
    chk("mid_rst_qready", q_ready_o, 1'b0);
    exp_q.delete();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    step(1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, 2'd2, 1'b1, o);
    chk("post_rst_acc", o.acc, 1'b1);
    chk("post_rst_stale", o.p_valid, 1'b0);
    idle(1'b1, o);
    chk("post_rst_data", o.p_data, 32'hDEAD_BEEF);
    idle(1'b1, o);
    chk("post_rst_nostale", o.p_valid, 1'b0);

`ifdef EXT_MEM_ERR_STATS_EN
    // ---- error statistics ----
    err_clr_i = 1'b1;
    idle(1'b1, o);
    err_clr_i = 1'b0;
    chk("st_clr_cnt", err_cnt_o, 16'h0);
    step(1'b1, 1'b0, 32'h0000_0FFC, 32'h0, 4'h0, 2'd2, 1'b1, o);
    step(1'b1, 1'b1, 32'h0002_1000, 32'h0, 4'hF, 2'd2, 1'b1, o);
    step(1'b1, 1'b0, 32'h0000_1002, 32'h0, 4'h0, 2'd2, 1'b1, o);
    chk("st_cnt3", err_cnt_o, 16'd3);
    chk("st_addr", err_addr_o, 32'h0000_1002);
    err_clr_i = 1'b1;
    step(1'b1, 1'b0, 32'h0000_0FF0, 32'h0, 4'h0, 2'd2, 1'b1, o);
    err_clr_i = 1'b0;
    chk("st_clr_wins", err_cnt_o, 16'h0);
    chk("st_clr_addr", err_addr_o, 32'h0);
    drain();
`endif

    // ---- randomized traffic against the model ----
    begin
      logic        have, rw;
      logic [31:0] ra, rd;
      logic [3:0]  rs;
      logic [1:0]  rsz;
      have = 1'b0; rw = 1'b0; ra = 32'h0; rd = 32'h0; rs = 4'h0; rsz = 2'd0;
      for (int n = 0; n < 400; n++) begin
        if (!have && $urandom_range(0, 3) != 0) begin
          have = 1'b1;
          rw   = 1'($urandom_range(0, 1));
          case ($urandom_range(0, 9))
            0:       ra = BASE - 32'(4 * $urandom_range(1, 4));
            1:       ra = BASE + SIZE + 32'(4 * $urandom_range(0, 3));
            2:       ra = BASE + SIZE - 32'(4 * $urandom_range(1, 4));
            default: ra = BASE + 32'($urandom_range(0, 63));
          endcase
          rsz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
          rd  = $urandom;
          rs  = 4'($urandom_range(0, 15));
        end
        step(have, rw, ra, rd, rs, rsz, ($urandom_range(0, 3) != 0), o);
        if (o.acc) have = 1'b0;
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ext_mem_reqrsp_ctrl.md
Name: ext_mem_reqrsp_ctrl

Overview:
- 32-bit reqrsp slave that terminates the external instruction/data memory path: consumes the reqrsp stream produced by the AXI-to-reqrsp stage and drives the TCM-style single-port SRAM directly.
- Replaces the bare adapter plus hand-written address offset with address-window decode, size/alignment checking, error responses and a response buffer that absorbs p_ready backpressure.
- Sits between axi_to_reqrsp and TCM_WRAP in the FPGA top, using the clock and reset of that domain.

Parameters:
- BASE_ADDR, 32'h0000_1000, byte address of first memory location.
- MEM_BYTES, 32'h0002_0000, window size in bytes; power of two, at least 8.
- RSP_DEPTH, 2, outstanding-response capacity; at least 2.
- AW, $clog2(MEM_BYTES), width of mem_addr_o (derived; not overridden).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- q_valid_i  in  1  request valid.
- q_ready_o  out  1  request ready.
- q_addr_i  in  32  byte address.
- q_write_i  in  1  1=write, 0=read.
- q_data_i  in  32  write data.
- q_strb_i  in  4  byte strobes.
- q_size_i  in  2  log2 access bytes; 0, 1 or 2.
- p_valid_o  out  1  response valid.
- p_ready_i  in  1  response ready.
- p_data_o  out  32  read data.
- p_error_o  out  1  access error.
- mem_en_o  out  1  SRAM enable.
- mem_we_o  out  1  SRAM write enable.
- mem_be_o  out  4  SRAM byte enables.
- mem_addr_o  out  AW  byte offset from BASE_ADDR.
- mem_wdata_o  out  32  SRAM write data.
- mem_rdata_i  in  32  SRAM read data, valid the cycle after mem_en_o.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: p_valid_o=0, p_data_o=0, p_error_o=0, and all mem_* outputs 0. q_ready_o is 0 while rst_ni=0 and 1 in the first cycle after release.
- Request handshake: a request is accepted when q_valid_i & q_ready_o. Request fields must be held stable while q_valid_i=1 and q_ready_o=0.
- Window decode:
  - off = q_addr_i - BASE_ADDR, 32-bit unsigned.
  - in_range = (q_addr_i >= BASE_ADDR) & (off < MEM_BYTES).
  - aligned = (off mod 2^q_size_i == 0); q_size_i=3 counts as misaligned.
  - ok = in_range & aligned.
- SRAM drive (combinational, same cycle as acceptance):
  - mem_en_o = accept & ok.
  - mem_we_o = q_write_i.
  - mem_be_o = q_strb_i for writes, 4'hF for reads.
  - mem_addr_o = off[AW-1:0]; mem_wdata_o = q_data_i.
  - A rejected access (ok=0) never asserts mem_en_o.
- Stage register s1 captures {valid, is_read, err} for every accepted request.
- Response FIFO holds RSP_DEPTH entries of {data, err}.
- Response output:
  - If the FIFO is non-empty, the FIFO head is presented.
  - Otherwise, if s1 is valid, s1 is presented with data = (is_read & ~err) ? mem_rdata_i : 0. This is a fall-through path.
  - A presented s1 entry that is not popped in the same cycle is pushed into the FIFO at the next edge.
- Latency and ordering: the response to a request accepted in cycle N is valid in cycle N+1 at the earliest. Responses return strictly in acceptance order. Throughput is 1 request/cycle while p_ready_i=1.
- Credit flow: occ = fifo_count + s1_valid; q_ready_o = rst_ni & (occ < RSP_DEPTH). The FIFO therefore never overflows.
  - Simultaneous FIFO push and pop keeps the count unchanged.
  - An empty FIFO with s1 invalid gives p_valid_o=0.
- Write responses: data=0, err=0.
- Error responses: data=0, err=1, with no side effect on memory.
- p_valid_o, once asserted, stays high with p_data_o and p_error_o stable until p_ready_i=1.
- Reset mid-operation: s1, the FIFO and all counters clear at once. In-flight responses are discarded and p_valid_o drops asynchronously.

Optional Feature:
- Macro: EXT_MEM_ERR_STATS_EN.
- When defined, three extra outputs are present:
  - err_cnt_o[15:0]: saturating count of accepted erroring requests; holds at 16'hFFFF.
  - err_addr_o[31:0]: q_addr_i of the most recent erroring request.
  - err_clr_i: synchronous clear of both outputs. Clear wins over a simultaneous increment.
  - Both outputs reset to 0.
- When undefined, these ports and registers do not exist; error responses behave identically.

Decomposition:
- Add to CC_ITF_PKG:
  - EXT_MEM_BASE = 32'h1000 and EXT_MEM_SIZE = 32'h0002_0000.
  - A packed ext_mem_rsp_t {data[31:0], err} used by the FIFO.
- Existing reqrsp_d32 typedefs are unpacked to the flat ports in the top.
- Sub-module ext_mem_rsp_fifo: parameterised depth, with push, pop, full, empty and head outputs.

Test Plan:
- Write 0x1000 data 0xDEADBEEF strb 4'hF, then read 0x1000 with p_ready=1:
  - mem_addr_o=0 on both accesses.
  - Write response err=0 in N+1.
  - Read response 0xDEADBEEF, err=0 in M+1.
- Back-to-back reads of 0x1004, 0x1008, 0x100C with p_ready=1: q_ready held at 1, three in-order responses on consecutive cycles.
- p_ready=0 while issuing 3 reads:
  - Exactly 2 accepted; q_ready=0 from the cycle occ reaches 2.
  - Raising p_ready drains both responses in order, then the third request is accepted.
- Out-of-window requests:
  - Read of 0x0FFC: err=1, data=0, mem_en_o never asserted.
  - Write to 0x0002_1000: err=1, memory contents unchanged.
  - Misaligned read of 0x1002 with size=2: err=1.
- Reset pulse while 2 responses are pending: p_valid drops immediately. After release, q_ready=1 and the next read returns the correct data with no stale responses.
- With EXT_MEM_ERR_STATS_EN:
  - 3 erroring requests give err_cnt_o=3 and err_addr_o equal to the last bad address.
  - err_clr_i asserted in the same cycle as a fourth error gives err_cnt_o=0.
